// File: rtl/viterbi_decoder_pkg.sv
// Shared definitions for the K=3, rate-1/2 hard-decision Viterbi decoder:
// trellis size, generator taps, controller states and branch-metric helpers.
package viterbi_decoder_pkg;

    localparam int NSTATES = 4;
    localparam logic [2:0] G0 = 3'b101;
    localparam logic [2:0] G1 = 3'b111;

    typedef enum logic [1:0] {
        ST_ACS   = 2'd0,
        ST_FIND  = 2'd1,
        ST_TRACE = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    // Code symbol {out1,out0} emitted when bit b enters an encoder holding s={d1,d2}.
    function automatic logic [1:0] expSym(input logic b, input logic [1:0] s);
        logic [2:0] reg3;
        reg3 = {b, s};
        return {^(reg3 & G1), ^(reg3 & G0)};
    endfunction

    function automatic logic [1:0] hamDist(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return 2'(x[1]) + 2'(x[0]);
    endfunction

endpackage

// File: rtl/viterbi_decoder_acs.sv
// Add-compare-select cell for one trellis state: saturating adds of both
// predecessor metrics, keeps the smaller, ties resolved towards predecessor d2=0.
module viterbi_acs #(
    parameter int MW = 8
) (
    input  logic [MW-1:0] pm0_i,
    input  logic [MW-1:0] pm1_i,
    input  logic [1:0]    bm0_i,
    input  logic [1:0]    bm1_i,
    output logic [MW-1:0] pm_o,
    output logic          surv_o
);

    logic [MW:0]   sum0;
    logic [MW:0]   sum1;
    logic [MW-1:0] sat0;
    logic [MW-1:0] sat1;

    assign sum0 = {1'b0, pm0_i} + {{(MW-1){1'b0}}, bm0_i};
    assign sum1 = {1'b0, pm1_i} + {{(MW-1){1'b0}}, bm1_i};
    assign sat0 = sum0[MW] ? {MW{1'b1}} : sum0[MW-1:0];
    assign sat1 = sum1[MW] ? {MW{1'b1}} : sum1[MW-1:0];

    assign surv_o = (sat1 < sat0);
    assign pm_o   = surv_o ? sat1 : sat0;

endmodule

// File: rtl/viterbi_decoder.sv
// Frame-based hard-decision Viterbi decoder (K=3, G1=111, G0=101), traceback over the whole frame.
// Optional VITERBI_METRIC_OUT_EN adds metric_o: best-path metric latched when traceback starts.
module viterbi_decoder
    import viterbi_decoder_pkg::*;
#(
    parameter int FRAME_LEN = 64,
    parameter int MW        = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          valid_i,
    input  logic [1:0]    data_i,
    output logic          ready_o,
    output logic          valid_o,
    output logic          data_o
`ifdef VITERBI_METRIC_OUT_EN
    ,
    output logic [MW-1:0] metric_o
`endif
);

    localparam int CW = $clog2(FRAME_LEN);
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
    localparam logic [MW-1:0] PM_INF = {MW{1'b1}};
    localparam logic [NSTATES-1:0][MW-1:0] PM_INIT = {{(NSTATES-1){PM_INF}}, {MW{1'b0}}};

    state_e                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [NSTATES-1:0][MW-1:0] pm_q, pm_d;
    logic [1:0]                st_q, st_d;

    logic [NSTATES-1:0][MW-1:0] acsMetric;
    logic [NSTATES-1:0]        acsSurv;
    logic [NSTATES-1:0]        surv_q [FRAME_LEN];
    logic [FRAME_LEN-1:0]      bits_q;
    logic [1:0]                bestState;
    logic [MW-1:0]             bestMetric;

    // Next state n={b,d1} is reached from {n[0],0} and {n[0],1} with input bit b=n[1].
    for (genvar n = 0; n < NSTATES; n++) begin : g_acs
        localparam logic [1:0] P0 = 2'((n % 2) * 2);
        localparam logic [1:0] P1 = 2'((n % 2) * 2 + 1);
        localparam logic       B  = 1'(n / 2);

        logic [1:0] bm0;
        logic [1:0] bm1;

        assign bm0 = hamDist(data_i, expSym(B, P0));
        assign bm1 = hamDist(data_i, expSym(B, P1));

        viterbi_acs #(.MW(MW)) u_acs (
            .pm0_i (pm_q[P0]),
            .pm1_i (pm_q[P1]),
            .bm0_i (bm0),
            .bm1_i (bm1),
            .pm_o  (acsMetric[n]),
            .surv_o(acsSurv[n])
        );
    end

    always_comb begin
        bestState  = 2'd0;
        bestMetric = pm_q[0];
        for (int i = 1; i < NSTATES; i++) begin
            if (pm_q[i] < bestMetric) begin
                bestState  = 2'(i);
                bestMetric = pm_q[i];
            end
        end
    end

    // One counter serves as symbol index, traceback time and output index.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pm_d    = pm_q;
        st_d    = st_q;
        ready_o = 1'b0;
        valid_o = 1'b0;
        case (state_q)
            ST_ACS: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    pm_d  = acsMetric;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = ST_FIND;
                    end
                end
            end
            ST_FIND: begin
                st_d    = bestState;
                cnt_d   = LAST;
                state_d = ST_TRACE;
            end
            ST_TRACE: begin
                st_d  = {st_q[0], surv_q[cnt_q][st_q]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                valid_o = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    pm_d    = PM_INIT;
                    state_d = ST_ACS;
                end
            end
            default: begin
                state_d = ST_ACS;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_ACS;
            cnt_q   <= '0;
            pm_q    <= PM_INIT;
            st_q    <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pm_q    <= pm_d;
            st_q    <= st_d;
        end
    end

    // Survivor and decoded-bit storage is always written before being read, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (state_q == ST_ACS && valid_i) begin
            surv_q[cnt_q] <= acsSurv;
        end
        if (state_q == ST_TRACE) begin
            bits_q[cnt_q] <= st_q[1];
        end
    end

    assign data_o = valid_o & bits_q[cnt_q];

`ifdef VITERBI_METRIC_OUT_EN
    logic [MW-1:0] metric_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            metric_q <= '0;
        end else if (state_q == ST_FIND) begin
            metric_q <= bestMetric;
        end
    end

    assign metric_o = metric_q;
`endif

endmodule

// File: tb/tb_viterbi_decoder.sv
// Testbench for viterbi_decoder: random payloads encoded by a reference convolutional encoder,
// decoded output, latency and reset behaviour checked with immediate assertions.
module tb_viterbi_decoder;

    localparam int FL = 64;
    localparam int MW = 8;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       valid_i = 1'b0;
    logic [1:0] data_i = 2'b00;
    logic       ready_o;
    logic       valid_o;
    logic       data_o;
`ifdef VITERBI_METRIC_OUT_EN
    logic [MW-1:0] metric_o;
`endif

    int nChecks = 0;
    int nFails  = 0;

    logic [1:0]  syms [FL];
    logic [63:0] payload;

    viterbi_decoder #(.FRAME_LEN(FL), .MW(MW)) dut (
        .CLK    (clk),
        .RST    (rstN),
        .valid_i(valid_i),
        .data_i (data_i),
        .ready_o(ready_o),
        .valid_o(valid_o),
        .data_o (data_o)
`ifdef VITERBI_METRIC_OUT_EN
        ,
        .metric_o(metric_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference encoder: register {d1,d2} starts cleared at every frame.
    task automatic encodeFrame(input logic [63:0] p);
        logic d1;
        logic d2;
        d1 = 1'b0;
        d2 = 1'b0;
        for (int i = 0; i < FL; i++) begin
            syms[i] = {p[i] ^ d1 ^ d2, p[i] ^ d2};
            d2 = d1;
            d1 = p[i];
        end
    endtask

    task automatic applyStimulus(input int gap, input bit holdHigh);
        for (int i = 0; i < FL; i++) begin
            int guard;
            guard = 0;
            while (!ready_o && guard < 300) begin
                tick();
                guard++;
            end
            checkOutput("readyBeforeSymbol", 64'(ready_o), 64'd1);
            if (!ready_o) begin
                valid_i = 1'b0;
                return;
            end
            valid_i = 1'b1;
            data_i  = syms[i];
            tick();
            if (i < FL - 1) begin
                for (int g = 0; g < gap; g++) begin
                    valid_i = 1'b0;
                    data_i  = 2'($urandom);
                    tick();
                end
            end
        end
        valid_i = holdHigh;
        data_i  = 2'($urandom);
    endtask

    task automatic collectFrame(input string tag, input logic [63:0] expBits,
                                input int expMetric, input bit holdHigh);
        int firstValid;
        int readyEdge;
        int nOut;
        logic [63:0] got;
        firstValid = -1;
        readyEdge  = -1;
        nOut       = 0;
        got        = '0;
        for (int k = 1; k <= 300 && readyEdge < 0; k++) begin
            if (holdHigh) begin
                data_i = 2'($urandom);
            end
            tick();
            if (valid_o) begin
                if (firstValid < 0) begin
                    firstValid = k;
                end
                if (nOut < FL) begin
                    got[nOut] = data_o;
                end
                nOut++;
            end
            if (ready_o) begin
                readyEdge = k;
            end
        end
        checkOutput({tag, ".firstValidEdge"}, 64'(firstValid), 64'd65);
        checkOutput({tag, ".readyReturnEdge"}, 64'(readyEdge), 64'd129);
        checkOutput({tag, ".validCycles"}, 64'(nOut), 64'(FL));
        checkOutput({tag, ".bits"}, got, expBits);
`ifdef VITERBI_METRIC_OUT_EN
        checkOutput({tag, ".metric"}, 64'(metric_o), 64'(expMetric));
`else
        if (expMetric < 0) begin
            $display("[TB] note: negative metric request for %s", tag);
        end
`endif
    endtask

    initial begin
        $display("[TB] start");

        tick();
        tick();
        checkOutput("reset.ready", 64'(ready_o), 64'd1);
        checkOutput("reset.valid", 64'(valid_o), 64'd0);
        checkOutput("reset.data", 64'(data_o), 64'd0);
`ifdef VITERBI_METRIC_OUT_EN
        checkOutput("reset.metric", 64'(metric_o), 64'd0);
`endif
        rstN = 1'b1;
        tick();

        payload = 64'd0;
        encodeFrame(payload);
        applyStimulus(0, 1'b0);
        collectFrame("allZero", payload, 0, 1'b0);

        payload = 64'd1;
        encodeFrame(payload);
        checkOutput("impulse.syms", {syms[0], syms[1], syms[2]}, 64'b11_10_11);
        applyStimulus(0, 1'b0);
        collectFrame("impulse", payload, 0, 1'b0);

        payload = {$urandom, $urandom};
        encodeFrame(payload);
        syms[20] = syms[20] ^ (2'b01 << $urandom_range(0, 1));
        applyStimulus(0, 1'b0);
        collectFrame("oneError", payload, 1, 1'b0);

        for (int f = 0; f < 2; f++) begin
            payload = {$urandom, $urandom};
            encodeFrame(payload);
            applyStimulus(0, 1'b0);
            collectFrame("randomClean", payload, 0, 1'b0);
        end

        payload = {$urandom, $urandom};
        encodeFrame(payload);
        applyStimulus(0, 1'b1);
        collectFrame("backToBackA", payload, 0, 1'b1);
        payload = {$urandom, $urandom};
        encodeFrame(payload);
        applyStimulus(0, 1'b0);
        collectFrame("backToBackB", payload, 0, 1'b0);

        payload = {$urandom, $urandom};
        encodeFrame(payload);
        applyStimulus(0, 1'b0);
        repeat (30) tick();
        checkOutput("midTrace.busy", 64'(ready_o), 64'd0);
        rstN = 1'b0;
        #1;
        checkOutput("midTrace.resetReady", 64'(ready_o), 64'd1);
        checkOutput("midTrace.resetValid", 64'(valid_o), 64'd0);
        tick();
        tick();
        rstN = 1'b1;
        tick();
        payload = {$urandom, $urandom};
        encodeFrame(payload);
        applyStimulus(0, 1'b0);
        collectFrame("afterTraceReset", payload, 0, 1'b0);

        payload = {$urandom, $urandom};
        encodeFrame(payload);
        applyStimulus(0, 1'b0);
        repeat (80) tick();
        checkOutput("midOut.valid", 64'(valid_o), 64'd1);
        rstN = 1'b0;
        #1;
        checkOutput("midOut.resetValid", 64'(valid_o), 64'd0);
        checkOutput("midOut.resetData", 64'(data_o), 64'd0);
        checkOutput("midOut.resetReady", 64'(ready_o), 64'd1);
`ifdef VITERBI_METRIC_OUT_EN
        checkOutput("midOut.resetMetric", 64'(metric_o), 64'd0);
`endif
        tick();
        rstN = 1'b1;
        tick();

        payload = {$urandom, $urandom};
        encodeFrame(payload);
        applyStimulus(2, 1'b0);
        collectFrame("gappedInput", payload, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
